// File: rtl/adder_truah_pipe.sv
// Two-stage multi-lane approximate signed adder/accumulator. Each lane forces the
// low k LSBs of A to 1 and of B to 0 before adding; the result saturates or wraps.
module adder_truah_pipe #(
  parameter int LANES      = 4,
  parameter int WIDTH_A    = 16,
  parameter int WIDTH_B    = 16,
  parameter int MAX_IGNORE = 8,
  parameter int SATURATE   = 1,
  localparam int BITS      = (WIDTH_A > WIDTH_B) ? WIDTH_A : WIDTH_B,
  localparam int IW        = $clog2(MAX_IGNORE + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*WIDTH_A-1:0] A,
  input  logic [LANES*WIDTH_B-1:0] B,
  input  logic [IW-1:0]           ignore_bits,
  input  logic                    mode,
  input  logic                    acc_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*BITS-1:0]   OUT,
  output logic [LANES-1:0]        ovf
);

  // Handshake: a beat moves when valid & ready are both high on a rising edge.
  // in_ready is combinational from out_ready; OUT/ovf/out_valid stay frozen while
  // out_valid = 1 and out_ready = 0.

  localparam logic [IW-1:0] MAX_K = IW'(MAX_IGNORE);
  localparam logic signed [BITS+1:0] SMAX = {3'b000, {(BITS-1){1'b1}}};
  localparam logic signed [BITS+1:0] SMIN = {3'b111, {(BITS-1){1'b0}}};
  localparam logic [BITS-1:0] SAT_HI = {1'b0, {(BITS-1){1'b1}}};
  localparam logic [BITS-1:0] SAT_LO = {1'b1, {(BITS-1){1'b0}}};

  logic v1, v2;
  logic adv1, adv2;
  logic mode1, clr1;
  logic signed [BITS-1:0] a1    [LANES];
  logic signed [BITS-1:0] b1    [LANES];
  logic signed [BITS-1:0] out_r [LANES];
  logic signed [BITS-1:0] acc   [LANES];
  logic [LANES-1:0]       ovf_r;

  assign adv2      = !v2 || out_ready;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1 && !rst;
  assign out_valid = v2;
  assign ovf       = ovf_r;

  // Stage-1 operand preparation
  logic [IW-1:0]          k;
  logic [BITS-1:0]        mask;
  logic signed [BITS-1:0] a_n [LANES];
  logic signed [BITS-1:0] b_n [LANES];

  always_comb begin
    k    = (ignore_bits > MAX_K) ? MAX_K : ignore_bits;
    mask = ~({BITS{1'b1}} << k);
    a_n  = '{default: '0};
    b_n  = '{default: '0};
    for (int i = 0; i < LANES; i++) begin
      a_n[i] = BITS'($signed(A[i*WIDTH_A +: WIDTH_A])) | mask;
      b_n[i] = BITS'($signed(B[i*WIDTH_B +: WIDTH_B])) & ~mask;
    end
  end

  // Stage-2 sum at BITS+2 so the range check never itself overflows
  logic signed [BITS-1:0] base;
  logic signed [BITS+1:0] s     [LANES];
  logic signed [BITS-1:0] res_n [LANES];
  logic [LANES-1:0]       ovf_n;

  always_comb begin
    base  = '0;
    s     = '{default: '0};
    res_n = '{default: '0};
    ovf_n = '0;
    for (int i = 0; i < LANES; i++) begin
      base     = (mode1 && !clr1) ? acc[i] : '0;
      s[i]     = (BITS+2)'(a1[i]) + (BITS+2)'(b1[i]) + (BITS+2)'(base);
      ovf_n[i] = (s[i] > SMAX) || (s[i] < SMIN);
      if ((SATURATE != 0) && ovf_n[i])
        res_n[i] = s[i][BITS+1] ? SAT_LO : SAT_HI;
      else
        res_n[i] = s[i][BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      mode1 <= 1'b0;
      clr1  <= 1'b0;
      ovf_r <= '0;
      for (int i = 0; i < LANES; i++) begin
        a1[i]    <= '0;
        b1[i]    <= '0;
        out_r[i] <= '0;
        acc[i]   <= '0;
      end
    end else begin
      if (adv1) begin
        v1 <= in_valid;
        if (in_valid) begin
          mode1 <= mode;
          clr1  <= acc_clr;
          for (int i = 0; i < LANES; i++) begin
            a1[i] <= a_n[i];
            b1[i] <= b_n[i];
          end
        end
      end
      // The accumulator loads only when a beat actually enters stage 2, so a
      // stalled output can never update it twice.
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          ovf_r <= ovf_n;
          for (int i = 0; i < LANES; i++) begin
            out_r[i] <= res_n[i];
            if (mode1) acc[i] <= res_n[i];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_out
    assign OUT[g*BITS +: BITS] = out_r[g];
  end

endmodule

// File: doc/adder_truah_pipe.md
# adder_truah_pipe

Pipelined, multi-lane approximate signed adder/accumulator for the systolic array datapath. Each lane adds two sign-extended operands after forcing a runtime-selectable number of LSBs of A to 1 and of B to 0. This is the lower-part truncation approximation, now with a per-beat ignore count. Adds valid/ready flow control, a two-stage pipeline, optional saturation with overflow flags, and a per-lane accumulate mode for partial-sum reduction at the array edge.

## Interface
- LANES, 4, number of independent lanes
- WIDTH_A, 16, per-lane width of A
- WIDTH_B, 16, per-lane width of B
- MAX_IGNORE, 8, largest honoured ignore count; must be < BITS
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap
- Derived: BITS = max(WIDTH_A, WIDTH_B); IW = $clog2(MAX_IGNORE+1)
- Clock/reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat offered
- in_ready  out  1  block accepts beat this cycle
- A  in  LANES*WIDTH_A  lane i at [i*WIDTH_A +: WIDTH_A], signed
- B  in  LANES*WIDTH_B  lane i at [i*WIDTH_B +: WIDTH_B], signed
- ignore_bits  in  IW  approximate LSB count for this beat
- mode  in  1  0 = add, 1 = accumulate
- acc_clr  in  1  accumulate beat starts from accumulator = 0
- out_valid  out  1  result beat available
- out_ready  in  1  downstream accepts result
- OUT  out  LANES*BITS  lane i at [i*BITS +: BITS], signed
- ovf  out  LANES  per-lane overflow flag for the current OUT beat

## Operation
- Beat transfer on in_valid & in_ready; output transfer on out_valid & out_ready.
- Stage 1 registers, per lane, a = sext(A_i), b = sext(B_i) to BITS. With k = min(ignore_bits, MAX_IGNORE): a[k-1:0] forced to all 1, b[k-1:0] forced to all 0. For k = 0, operands are unchanged. It also registers mode and acc_clr.
- Stage 2 computes s = a + b + base at BITS+2 width. base = 0 when mode = 0. base = 0 when mode = 1 and acc_clr = 1. Otherwise base = acc_i.
- Range check: ovf_i = 1 when s < -2^(BITS-1) or s > 2^(BITS-1)-1.
- SATURATE = 1: OUT_i is clamped to 0x8000.../0x7FFF...
- SATURATE = 0: OUT_i = s[BITS-1:0].
- Accumulator acc_i (BITS) loads OUT_i whenever a mode = 1 beat enters stage 2. Mode = 0 beats leave acc untouched.
- Lanes are fully independent. A saturated lane does not affect other lanes.

## Timing
- Reset: in_ready = 0 while rst = 1. out_valid, both stage valids, OUT, ovf and all acc_i are 0. in_ready = 1 the first cycle after rst is deasserted.
- Latency: 2 cycles from input transfer to out_valid, with no stall. Throughput is 1 beat/cycle.
- Stage advance: adv2 = !v2 | out_ready; adv1 = !v1 | adv2. in_ready = adv1 & !rst, which is combinational from out_ready.
- Full condition: v1 = v2 = 1 and out_ready = 0 gives in_ready = 0. At most 2 beats are held, with no loss or reordering.
- OUT, ovf and out_valid hold stable while out_valid = 1 and out_ready = 0.
- acc_i updates exactly once per accumulate beat, on its stage-2 load. Stalls never cause a double update.
- Back-to-back accumulate beats use the accumulator value produced by the previous beat, with no bubble.
- ignore_bits > MAX_IGNORE is clipped to MAX_IGNORE. It is sampled per beat, so changing it between beats is legal.
- rst mid-operation discards in-flight beats and clears accumulators on the same edge.

## Test plan
- BITS = 16, mode 0, ignore 4, A = 0x0013, B = 0x0025 -> OUT = 0x003F, ovf = 0, out_valid exactly 2 cycles after transfer.
- SATURATE = 1, ignore 0, A = 0x7FFF, B = 0x0001 -> OUT = 0x7FFF, ovf = 1. A = 0x8000, B = 0xFFFF -> OUT = 0x8000, ovf = 1. With SATURATE = 0, same inputs -> OUT = 0x8000 and 0x7FFF.
- Mode 1, ignore 0, A = 10, B = 5 for 3 beats, acc_clr on the first beat only -> OUT = 15, 30, 45. A 4th beat with acc_clr = 1 -> OUT = 15.
- Hold out_ready = 0 for 4 cycles with in_valid high: only 2 beats accepted, in_ready = 0 from cycle 3, outputs stable. After release, all beats emerge in order and the accumulator advances once per beat.
- ignore_bits = 15 with MAX_IGNORE = 8, A = 0, B = 0x0100 -> OUT = 0x01FF.
- Assert rst while 2 beats are in flight and acc = 45 -> next cycle out_valid = 0 and acc = 0. A following accumulate beat A = 1, B = 1 gives OUT = 2.
